// File: rtl/pulse_led_pkg.sv
// Shared types for the pulse_led_array block.
// Optional square-law brightness is selected with the PULSE_LED_GAMMA_EN macro
// (see pulse_led_channel.sv).
package pulse_led_pkg;

  typedef enum logic [1:0] {
    MODE_BREATHE = 2'd0,
    MODE_ON      = 2'd1,
    MODE_OFF     = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pulse_led_channel.sv
// One triangle-ramp duty generator: duty/dir register pair plus the PWM compare.
// PULSE_LED_GAMMA_EN: compare counter*PERIOD < duty*duty (square-law) instead of
// the linear counter < duty. Endpoints 0 and PERIOD behave identically.
module pulse_led_channel
  import pulse_led_pkg::*;
#(
  parameter int CNT_W  = 20,
  parameter int PERIOD = 500000,
  parameter int STEP   = 20000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] counter,
  input  logic             wrap,
  input  logic             enable,
  input  logic [CNT_W-1:0] rst_duty,
  output logic             cmp
);

  // One extra bit so duty+STEP can never wrap before the clamp.
  localparam logic [CNT_W:0] PERIOD_W = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0] STEP_W   = (CNT_W+1)'(STEP);

  logic [CNT_W-1:0] duty_q, duty_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W:0]   sum;

  // Ramp step once per period, clamping and turning at both ends.
  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    sum    = {1'b0, duty_q} + STEP_W;
    if (wrap && enable) begin
      if (dir_q == DIR_UP) begin
        if (sum >= PERIOD_W) begin
          duty_d = PERIOD_W[CNT_W-1:0];
          dir_d  = DIR_DOWN;
        end else begin
          duty_d = sum[CNT_W-1:0];
        end
      end else begin
        if ({1'b0, duty_q} <= STEP_W) begin
          duty_d = '0;
          dir_d  = DIR_UP;
        end else begin
          duty_d = duty_q - STEP_W[CNT_W-1:0];
        end
      end
    end
  end

  // Duty/dir state; reset loads the channel's staggered starting duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= rst_duty;
      dir_q  <= DIR_UP;
    end else begin
      duty_q <= duty_d;
      dir_q  <= dir_d;
    end
  end

`ifdef PULSE_LED_GAMMA_EN
  logic [2*CNT_W-1:0] lhs, rhs;
  // Square-law compare without division: c/P < (d/P)^2  <=>  c*P < d*d.
  always_comb begin
    lhs = (2*CNT_W)'(counter) * (2*CNT_W)'(PERIOD);
    rhs = (2*CNT_W)'(duty_q) * (2*CNT_W)'(duty_q);
    cmp = (lhs < rhs);
  end
`else
  // Linear PWM compare.
  always_comb begin
    cmp = (counter < duty_q);
  end
`endif

endmodule

// File: rtl/pulse_led_array.sv
// Multi-channel breathing LED driver: one shared period counter, CHANNELS ramp
// generators, global mode select, enable/freeze and a period tick.
// Build option PULSE_LED_GAMMA_EN selects the square-law brightness compare.
module pulse_led_array
  import pulse_led_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 20,
  parameter int PERIOD   = 500000,
  parameter int STEP     = 20000,
  parameter int STAGGER  = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] led,
  output logic                period_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]    counter_q, counter_d;
  logic                tick_q, tick_d;
  logic                blink_q, blink_d;
  logic [CHANNELS-1:0] led_q, led_d;
  logic [CHANNELS-1:0] raw;
  logic                at_end, wrap_en;

  assign at_end  = (counter_q == CNT_MAX);
  assign wrap_en = enable && at_end;

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      localparam logic [CNT_W-1:0] RST_DUTY =
        (i * STAGGER >= PERIOD) ? CNT_W'(PERIOD) : CNT_W'(i * STAGGER);
      pulse_led_channel #(
        .CNT_W (CNT_W),
        .PERIOD(PERIOD),
        .STEP  (STEP)
      ) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .counter (counter_q),
        .wrap    (at_end),
        .enable  (enable),
        .rst_duty(RST_DUTY),
        .cmp     (raw[i])
      );
    end
  endgenerate

  // Counter, tick, blink phase and LED mux; everything freezes while disabled.
  always_comb begin
    counter_d = counter_q;
    blink_d   = blink_q;
    tick_d    = wrap_en;
    led_d     = '0;
    if (enable) begin
      counter_d = at_end ? '0 : counter_q + 1'b1;
      if (at_end) blink_d = ~blink_q;
      case (mode_e'(mode))
        MODE_BREATHE: led_d = raw;
        MODE_ON:      led_d = '1;
        MODE_OFF:     led_d = '0;
        MODE_BLINK:   led_d = {CHANNELS{blink_q}};
        default:      led_d = '0;
      endcase
    end
  end

  // Shared state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      tick_q    <= 1'b0;
      blink_q   <= 1'b0;
      led_q     <= '0;
    end else begin
      counter_q <= counter_d;
      tick_q    <= tick_d;
      blink_q   <= blink_d;
      led_q     <= led_d;
    end
  end

  assign led         = led_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pulse_led_array.sv
// Self-checking bench for pulse_led_array (PERIOD=10, STEP=4, STAGGER=5, 2 ch),
// plus two small instances for the STEP=10 and STEP=3 boundary ramps.
module tb_pulse_led_array;

  localparam int P  = 10;
  localparam int ST = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       en_on = 1'b1;
  logic [1:0] mode_br = 2'd0;

  logic [1:0] led;
  logic       tick;
  logic [0:0] led_a;
  logic       tick_a;
  logic [1:0] led_b;
  logic       tick_b;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  pulse_led_array #(.CHANNELS(2), .CNT_W(8), .PERIOD(P), .STEP(ST), .STAGGER(5)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .led(led), .period_tick(tick));

  pulse_led_array #(.CHANNELS(1), .CNT_W(8), .PERIOD(P), .STEP(10), .STAGGER(5)) u_s10 (
    .clk(clk), .rst_n(rst_n), .enable(en_on), .mode(mode_br), .led(led_a), .period_tick(tick_a));

  pulse_led_array #(.CHANNELS(2), .CNT_W(8), .PERIOD(P), .STEP(3), .STAGGER(9)) u_s3 (
    .clk(clk), .rst_n(rst_n), .enable(en_on), .mode(mode_br), .led(led_b), .period_tick(tick_b));

  task automatic check(string name, int act, int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model (main DUT) ----------------
  int m_cnt;
  int m_duty[2];
  bit m_up[2];
  bit m_blink;
  int hc[2];
  int q0[$];
  int q1[$];

  function automatic bit bright(int c, int d);
`ifdef PULSE_LED_GAMMA_EN
    return (c * P < d * d);
`else
    return (c < d);
`endif
  endfunction

  // Expected outputs from the pre-edge model state, then advance the model.
  always @(posedge clk or negedge rst_n) begin
    int el, et;
    if (!rst_n) begin
      m_cnt = 0;
      m_blink = 0;
      for (int i = 0; i < 2; i++) begin
        m_duty[i] = (i * 5 < P) ? i * 5 : P;
        m_up[i] = 1;
        hc[i] = 0;
      end
      q0 = {};
      q1 = {};
      #1;
      check("rst_led", int'(led), 0);
      check("rst_tick", int'(tick), 0);
    end else begin
      el = 0;
      if (enable) begin
        case (mode)
          2'd0: el = int'(bright(m_cnt, m_duty[0])) + 2 * int'(bright(m_cnt, m_duty[1]));
          2'd1: el = 3;
          2'd2: el = 0;
          default: el = m_blink ? 3 : 0;
        endcase
      end
      et = (enable && m_cnt == P - 1) ? 1 : 0;
      if (enable) begin
        if (m_cnt == P - 1) begin
          m_cnt = 0;
          m_blink = !m_blink;
          for (int i = 0; i < 2; i++) begin
            if (m_up[i]) begin
              m_duty[i] = (m_duty[i] + ST > P) ? P : m_duty[i] + ST;
              if (m_duty[i] == P) m_up[i] = 0;
            end else begin
              m_duty[i] = (m_duty[i] - ST < 0) ? 0 : m_duty[i] - ST;
              if (m_duty[i] == 0) m_up[i] = 1;
            end
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      #1;
      check("led", int'(led), el);
      check("tick", int'(tick), et);
      hc[0] += el & 1;
      hc[1] += (el >> 1) & 1;
      if (et == 1) begin
        q0.push_back(hc[0]);
        q1.push_back(hc[1]);
        hc[0] = 0;
        hc[1] = 0;
      end
    end
  end

  // ---------------- boundary instances: per-period high counts ----------------
  int ha, hb0, hb1;
  int qa[$];
  int qb0[$];
  int qb1[$];
  initial begin ha = 0; hb0 = 0; hb1 = 0; end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      ha  += int'(led_a[0]);
      hb0 += int'(led_b[0]);
      hb1 += int'(led_b[1]);
      if (tick_a && qa.size() < 4) qa.push_back(ha);
      if (tick_a) ha = 0;
      if (tick_b && qb0.size() < 4) begin qb0.push_back(hb0); qb1.push_back(hb1); end
      if (tick_b) begin hb0 = 0; hb1 = 0; end
    end
  end

  task automatic check_ramp_lists(string tag);
`ifdef PULSE_LED_GAMMA_EN
    int e0[7] = '{0, 2, 7, 10, 4, 1, 0};
    int e1[7] = '{3, 9, 10, 4, 1, 0, 2};
`else
    int e0[7] = '{0, 4, 8, 10, 6, 2, 0};
    int e1[7] = '{5, 9, 10, 6, 2, 0, 4};
`endif
    check({tag, "_nper"}, q0.size(), 7);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s_ch0_p%0d", tag, k), (k < q0.size()) ? q0[k] : -1, e0[k]);
      check($sformatf("%s_ch1_p%0d", tag, k), (k < q1.size()) ? q1[k] : -1, e1[k]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tk, lat;
`ifdef PULSE_LED_GAMMA_EN
    int eb0[4] = '{0, 1, 4, 9};
    int eb1[4] = '{9, 10, 5, 2};
`else
    int eb0[4] = '{0, 3, 6, 9};
    int eb1[4] = '{9, 10, 7, 4};
`endif
    int ea[4] = '{0, 10, 0, 10};

    // Test 1: free-running breathe from reset.
    enable = 1'b1;
    mode = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    check_ramp_lists("t1");

    // Boundary ramps: STEP=PERIOD alternation and STEP=3 clamp from duty 9.
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s10_p%0d", k), (k < qa.size()) ? qa[k] : -1, ea[k]);
      check($sformatf("s3_ch0_p%0d", k), (k < qb0.size()) ? qb0[k] : -1, eb0[k]);
      check($sformatf("s3_ch1_p%0d", k), (k < qb1.size()) ? qb1[k] : -1, eb1[k]);
    end

    // Test 2: mode switching mid-run; ramps keep advancing underneath.
    mode = 2'd1;
    repeat (2) @(negedge clk);
    check("mode_on", int'(led), 3);
    repeat (7) @(negedge clk);
    mode = 2'd2;
    repeat (2) @(negedge clk);
    check("mode_off", int'(led), 0);
    repeat (6) @(negedge clk);
    mode = 2'd3;
    repeat (23) @(negedge clk);
    mode = 2'd0;
    repeat (25) @(negedge clk);

    // Test 3: freeze at counter=3 for 25 cycles.
    for (int k = 0; k < 20; k++) begin
      if (m_cnt == 3) break;
      @(negedge clk);
    end
    check("freeze_at_3", m_cnt, 3);
    enable = 1'b0;
    tk = 0;
    repeat (25) begin
      @(negedge clk);
      tk += int'(tick);
    end
    check("frozen_ticks", tk, 0);
    enable = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (tick) begin lat = k; break; end
    end
    check("resume_latency", lat, 7);
    repeat (30) @(negedge clk);

    // Test 4: asynchronous reset between edges while LEDs are lit.
    mode = 2'd1;
    repeat (3) @(negedge clk);
    check("pre_rst_led", int'(led), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_tick", int'(tick), 0);
    mode = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    check_ramp_lists("t4");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
